pkt_inject_arbiter: RTL

PKT_INJECT_ARBITER -- requirements
Module: pkt_inject_arbiter

---
 rtl/pkt_inject_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pkt_inject_arbiter.sv
// Round-robin arbiter that lets NUM_REQ PE packetizers share a single router
// injection port. An accepted packet lands in a one-entry output register;
// a new packet can be accepted in the same cycle the held one drains, so a
// steady stream runs at one packet per cycle.
//
// Optional feature: define PKT_ARB_STATS_EN to add a 16-bit wrapping counter
// of output transfers (pkt_count).
module pkt_inject_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PACKET_WIDTH = 33,
    parameter int ADDR_WIDTH   = 4,
    localparam int SrcW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_packet,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            out_valid,
    output logic [PACKET_WIDTH-1:0]         out_packet,
    input  logic                            out_ready,
    output logic [SrcW-1:0]                 out_src_id
`ifdef PKT_ARB_STATS_EN
    ,
    output logic [15:0]                     pkt_count
`endif
);

    // Header = spare bit + dest + src; the arbiter forwards it untouched.
    localparam int HdrW = 1 + 2 * ADDR_WIDTH;

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e                  state_q, state_d;
    logic [SrcW-1:0]         last_grant_q;
    logic [PACKET_WIDTH-1:0] out_packet_q;
    logic [SrcW-1:0]         out_src_id_q;

    logic                    grant_found;
    logic [SrcW-1:0]         grant_idx;
    int                      cand;
    logic [SrcW-1:0]         cand_idx;
    logic                    slot_free;
    logic                    accept;
    logic [PACKET_WIDTH-1:0] grant_packet;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(last_grant_q) + 1 + k) % NUM_REQ;
            cand_idx = SrcW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign slot_free    = (state_q == StEmpty) || out_ready;
    assign grant_packet = req_packet[grant_idx*PACKET_WIDTH +: PACKET_WIDTH];

    // Ready goes only to the winner, and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (!reset && slot_free && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |req_ready;

    // Next-state logic of the one-entry output slot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (out_ready && !accept) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Slot state register; reset discards any held packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer moves only on an actual handshake, so a requester that drops
    // valid before being accepted does not consume a turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= SrcW'(NUM_REQ - 1);
        end else if (accept) begin
            last_grant_q <= grant_idx;
        end
    end

    // Output payload register; held stable whenever nothing is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_packet_q <= '0;
            out_src_id_q <= '0;
        end else if (accept) begin
            out_packet_q <= grant_packet;
            out_src_id_q <= grant_idx;
        end
    end

    assign out_valid  = (state_q == StFull);
    assign out_packet = out_packet_q;
    assign out_src_id = out_src_id_q;

    logic [HdrW-1:0] unused_hdr;
    assign unused_hdr = out_packet_q[PACKET_WIDTH-1 -: HdrW];

`ifdef PKT_ARB_STATS_EN
    logic [15:0] pkt_count_q;

    // Count output transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (out_valid && out_ready) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule
